// File: rtl/pipe_ctrl_if.sv
// Hold/redirect bundle between the pipeline controller and the core stages.
// The slave side is the controller; the master side drives requests and consumes hold/redirect.
interface pipe_ctrl_if;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_ex_i;
  logic        hold_flag_rib_i;
  logic        jtag_halt_flag_i;
  logic        int_assert_i;
  logic [31:0] int_addr_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        halted_o;
  logic        bus_timeout_o;
  logic [31:0] hold_cycles_o;

  modport master (
    output jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_rib_i,
           jtag_halt_flag_i, int_assert_i, int_addr_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, halted_o, bus_timeout_o, hold_cycles_o
  );

  modport slave (
    input  jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_rib_i,
           jtag_halt_flag_i, int_assert_i, int_addr_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, halted_o, bus_timeout_o, hold_cycles_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: arbitrates stalls and redirects, stretches flushes over
// the fetch latency, flags stuck bus waits and counts held cycles.
module pipe_ctrl #(
  parameter int FLUSH_LEN = 2,
  parameter int BUS_TMO   = 255
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  localparam int CW = $clog2(FLUSH_LEN + 1);
  localparam logic [CW-1:0] FLUSH_RELOAD = CW'(FLUSH_LEN - 1);
  localparam bit USE_FLUSH = (FLUSH_LEN > 1);
  localparam logic [15:0] TMO_LAST = 16'(BUS_TMO - 1);

  typedef enum logic [1:0] {RUN, STALL, FLUSH, HALT} state_t;

  state_t        state, state_next;
  logic [CW-1:0] flush_cnt, flush_cnt_next;
  logic [15:0]   tmo_cnt;
  logic          halted_q;
  logic          bus_timeout_q;
  logic [31:0]   hold_cycles_q;
  logic          redirect;
  logic [2:0]    req_level;
  logic [2:0]    state_level;
  logic [2:0]    hold_level;

  assign redirect = bus.jump_flag_i | bus.int_assert_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      flush_cnt <= '0;
      halted_q  <= 1'b0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      halted_q  <= (state_next == HALT);
    end
  end

  // Halt outranks flush outranks stall; an active flush only yields to halt once it has drained.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      RUN, STALL: begin
        if (bus.jtag_halt_flag_i) begin
          state_next = HALT;
        end else if (redirect && USE_FLUSH) begin
          state_next     = FLUSH;
          flush_cnt_next = FLUSH_RELOAD;
        end else if (bus.hold_flag_ex_i) begin
          state_next = STALL;
        end else begin
          state_next = RUN;
        end
      end
      FLUSH: begin
        if (redirect) begin
          flush_cnt_next = FLUSH_RELOAD;
        end else if (flush_cnt <= CW'(1)) begin
          state_next     = bus.jtag_halt_flag_i ? HALT : RUN;
          flush_cnt_next = '0;
        end else begin
          flush_cnt_next = flush_cnt - CW'(1);
        end
      end
      HALT: begin
        if (!bus.jtag_halt_flag_i) state_next = RUN;
      end
      default: begin
        state_next     = RUN;
        flush_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    req_level = HOLD_NONE;
    if (redirect || bus.hold_flag_ex_i || bus.jtag_halt_flag_i) req_level = HOLD_ID;
    else if (bus.hold_flag_rib_i)                               req_level = HOLD_PC;
    state_level = (state == FLUSH || state == HALT) ? HOLD_ID : HOLD_NONE;
    hold_level  = (req_level > state_level) ? req_level : state_level;

    bus.hold_flag_o = rst ? hold_level : HOLD_NONE;
    bus.jump_flag_o = rst & redirect;
    bus.jump_addr_o = 32'h0;
    if (rst) begin
      if (bus.int_assert_i)     bus.jump_addr_o = bus.int_addr_i;
      else if (bus.jump_flag_i) bus.jump_addr_o = bus.jump_addr_i;
    end
  end

  // The timeout pulse restarts the window, so a permanently stuck bus pulses every BUS_TMO cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt       <= '0;
      bus_timeout_q <= 1'b0;
    end else if (bus.hold_flag_rib_i) begin
      if (tmo_cnt == TMO_LAST) begin
        tmo_cnt       <= '0;
        bus_timeout_q <= 1'b1;
      end else begin
        tmo_cnt       <= tmo_cnt + 16'd1;
        bus_timeout_q <= 1'b0;
      end
    end else begin
      tmo_cnt       <= '0;
      bus_timeout_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cycles_q <= '0;
    end else if (hold_level != HOLD_NONE && hold_cycles_q != 32'hFFFF_FFFF) begin
      hold_cycles_q <= hold_cycles_q + 32'd1;
    end
  end

  assign bus.halted_o      = halted_q;
  assign bus.bus_timeout_o = bus_timeout_q;
  assign bus.hold_cycles_o = hold_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with FLUSH_LEN=2 and BUS_TMO=4; inputs change on the falling
// edge and outputs are sampled 1 time unit later.
module tb_pipe_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.FLUSH_LEN(2), .BUS_TMO(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.jump_flag_i      = 1'b0;
    bus.jump_addr_i      = 32'h0;
    bus.hold_flag_ex_i   = 1'b0;
    bus.hold_flag_rib_i  = 1'b0;
    bus.jtag_halt_flag_i = 1'b0;
    bus.int_assert_i     = 1'b0;
    bus.int_addr_i       = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.jump_flag_i = 1'b1; bus.jump_addr_i = 32'h123; bus.hold_flag_ex_i = 1'b1;
    bus.hold_flag_rib_i = 1'b1; bus.jtag_halt_flag_i = 1'b1;
    bus.int_assert_i = 1'b1; bus.int_addr_i = 32'h456;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.hold_flag_o !== 3'd0) begin n_fails++; $display("[TB] FAIL reset_hold: got %0d expected 0", bus.hold_flag_o); end
    n_checks++;
    if (bus.jump_flag_o !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_jump_flag: got %b expected 0", bus.jump_flag_o); end
    n_checks++;
    if (bus.jump_addr_o !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_jump_addr: got %h expected 0", bus.jump_addr_o); end
    n_checks++;
    if (bus.halted_o !== 1'b0 || bus.bus_timeout_o !== 1'b0) begin
      n_fails++; $display("[TB] FAIL reset_flags: got halted=%b tmo=%b expected 0/0", bus.halted_o, bus.bus_timeout_o);
    end
    n_checks++;
    if (bus.hold_cycles_o !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_hold_cycles: got %0d expected 0", bus.hold_cycles_o); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.hold_flag_o !== 3'd0 || bus.hold_cycles_o !== 32'h0) begin
      n_fails++; $display("[TB] FAIL reset_release_idle: got hold=%0d cycles=%0d expected 0/0", bus.hold_flag_o, bus.hold_cycles_o);
    end
    @(negedge clk);
    bus.hold_flag_ex_i = 1'b1;
    #1;
    n_checks++;
    if (bus.hold_flag_o !== 3'd3) begin n_fails++; $display("[TB] FAIL reset_first_stall: got %0d expected 3", bus.hold_flag_o); end
    @(negedge clk);
    bus.hold_flag_ex_i = 1'b0;
    #1;
    n_checks++;
    if (bus.hold_flag_o !== 3'd0 || bus.hold_cycles_o !== 32'd1) begin
      n_fails++; $display("[TB] FAIL reset_count_from_zero: got hold=%0d cycles=%0d expected 0/1", bus.hold_flag_o, bus.hold_cycles_o);
    end
  endtask

  task automatic test_jump();
    do_reset();
    bus.jump_flag_i = 1'b1; bus.jump_addr_i = 32'h100;
    #1;
    n_checks++;
    if (bus.jump_flag_o !== 1'b1 || bus.jump_addr_o !== 32'h100) begin
      n_fails++; $display("[TB] FAIL jump_redirect: got flag=%b addr=%h expected 1/00000100", bus.jump_flag_o, bus.jump_addr_o);
    end
    n_checks++;
    if (bus.hold_flag_o !== 3'd3) begin n_fails++; $display("[TB] FAIL jump_hold_c0: got %0d expected 3", bus.hold_flag_o); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_checks++;
    if (bus.hold_flag_o !== 3'd3 || bus.jump_flag_o !== 1'b0) begin
      n_fails++; $display("[TB] FAIL jump_hold_c1: got hold=%0d flag=%b expected 3/0", bus.hold_flag_o, bus.jump_flag_o);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.hold_flag_o !== 3'd0) begin n_fails++; $display("[TB] FAIL jump_hold_c2: got %0d expected 0", bus.hold_flag_o); end
    n_checks++;
    if (bus.hold_cycles_o !== 32'd2) begin n_fails++; $display("[TB] FAIL jump_hold_cycles: got %0d expected 2", bus.hold_cycles_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.jump_flag_i = 1'b1; bus.jump_addr_i = 32'h100;
    bus.int_assert_i = 1'b1; bus.int_addr_i = 32'h80;
    #1;
    n_checks++;
    if (bus.jump_addr_o !== 32'h80 || bus.jump_flag_o !== 1'b1) begin
      n_fails++; $display("[TB] FAIL int_wins: got flag=%b addr=%h expected 1/00000080", bus.jump_flag_o, bus.jump_addr_o);
    end
    @(negedge clk);
    clear_inputs();
    bus.jump_flag_i = 1'b1; bus.jump_addr_i = 32'h200;
    #1;
    n_checks++;
    if (bus.jump_addr_o !== 32'h200 || bus.hold_flag_o !== 3'd3) begin
      n_fails++; $display("[TB] FAIL b2b_c1: got addr=%h hold=%0d expected 00000200/3", bus.jump_addr_o, bus.hold_flag_o);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_checks++;
    if (bus.hold_flag_o !== 3'd3) begin n_fails++; $display("[TB] FAIL b2b_reload_c2: got %0d expected 3", bus.hold_flag_o); end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.hold_flag_o !== 3'd0 || bus.hold_cycles_o !== 32'd3) begin
      n_fails++; $display("[TB] FAIL b2b_end: got hold=%0d cycles=%0d expected 0/3", bus.hold_flag_o, bus.hold_cycles_o);
    end
    bus.int_assert_i = 1'b1; bus.int_addr_i = 32'hABC;
    #1;
    n_checks++;
    if (bus.jump_addr_o !== 32'hABC || bus.jump_flag_o !== 1'b1) begin
      n_fails++; $display("[TB] FAIL int_only: got flag=%b addr=%h expected 1/00000abc", bus.jump_flag_o, bus.jump_addr_o);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_stall();
    logic       ex  [8];
    logic       rib [8];
    logic [2:0] exp_hold [8];
    do_reset();
    ex       = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    rib      = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_hold = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd1, 3'd1, 3'd0};
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      bus.hold_flag_ex_i  = ex[i];
      bus.hold_flag_rib_i = rib[i];
      #1;
      n_checks++;
      if (bus.hold_flag_o !== exp_hold[i]) begin
        n_fails++; $display("[TB] FAIL stall_hold_c%0d: got %0d expected %0d", i, bus.hold_flag_o, exp_hold[i]);
      end
      if (i == 6) begin
        n_checks++;
        if (bus.bus_timeout_o !== 1'b1) begin n_fails++; $display("[TB] FAIL stall_rib_timeout: got %b expected 1", bus.bus_timeout_o); end
      end
      if (i == 7) begin
        n_checks++;
        if (bus.bus_timeout_o !== 1'b0 || bus.hold_cycles_o !== 32'd7) begin
          n_fails++; $display("[TB] FAIL stall_end: got tmo=%b cycles=%0d expected 0/7", bus.bus_timeout_o, bus.hold_cycles_o);
        end
      end
    end
  endtask

  task automatic test_bus_timeout();
    logic exp_tmo [11];
    do_reset();
    exp_tmo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      bus.hold_flag_rib_i = (i < 10);
      #1;
      n_checks++;
      if (bus.bus_timeout_o !== exp_tmo[i]) begin
        n_fails++; $display("[TB] FAIL tmo_pulse_c%0d: got %b expected %b", i, bus.bus_timeout_o, exp_tmo[i]);
      end
      n_checks++;
      if (bus.hold_flag_o !== ((i < 10) ? 3'd1 : 3'd0)) begin
        n_fails++; $display("[TB] FAIL tmo_hold_c%0d: got %0d expected %0d", i, bus.hold_flag_o, (i < 10) ? 1 : 0);
      end
    end
    n_checks++;
    if (bus.hold_cycles_o !== 32'd10) begin n_fails++; $display("[TB] FAIL tmo_hold_cycles: got %0d expected 10", bus.hold_cycles_o); end
    clear_inputs();
  endtask

  task automatic test_halt();
    logic       halt_in  [6];
    logic [2:0] exp_hold [6];
    logic       exp_halt [6];
    do_reset();
    halt_in  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_hold = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0};
    exp_halt = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      clear_inputs();
      bus.jtag_halt_flag_i = halt_in[i];
      if (i == 0) begin bus.jump_flag_i = 1'b1; bus.jump_addr_i = 32'h40; end
      if (i == 3) begin bus.jump_flag_i = 1'b1; bus.jump_addr_i = 32'h300; end
      #1;
      n_checks++;
      if (bus.hold_flag_o !== exp_hold[i] || bus.halted_o !== exp_halt[i]) begin
        n_fails++;
        $display("[TB] FAIL halt_c%0d: got hold=%0d halted=%b expected %0d/%b", i, bus.hold_flag_o, bus.halted_o, exp_hold[i], exp_halt[i]);
      end
      if (i == 3) begin
        n_checks++;
        if (bus.jump_flag_o !== 1'b1 || bus.jump_addr_o !== 32'h300) begin
          n_fails++; $display("[TB] FAIL halt_redirect: got flag=%b addr=%h expected 1/00000300", bus.jump_flag_o, bus.jump_addr_o);
        end
      end
    end
    n_checks++;
    if (bus.hold_cycles_o !== 32'd5) begin n_fails++; $display("[TB] FAIL halt_hold_cycles: got %0d expected 5", bus.hold_cycles_o); end
    @(negedge clk);
    bus.jtag_halt_flag_i = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.halted_o !== 1'b1) begin n_fails++; $display("[TB] FAIL halt_reentry: got %b expected 1", bus.halted_o); end
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.halted_o !== 1'b0 || bus.hold_flag_o !== 3'd0 || bus.hold_cycles_o !== 32'h0) begin
      n_fails++;
      $display("[TB] FAIL halt_async_reset: got halted=%b hold=%0d cycles=%0d expected 0/0/0", bus.halted_o, bus.hold_flag_o, bus.hold_cycles_o);
    end
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.hold_flag_o !== 3'd0 || bus.halted_o !== 1'b0) begin
      n_fails++; $display("[TB] FAIL halt_after_reset: got hold=%0d halted=%b expected 0/0", bus.hold_flag_o, bus.halted_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b0;
    clear_inputs();
    test_reset();
    test_jump();
    test_back_to_back();
    test_stall();
    test_bus_timeout();
    test_halt();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end
endmodule
